// File: rtl/mem_stage_pkg.sv
// Shared definitions for the MEM-stage load/store unit: funct3 encodings, FSM states and
// the access-size helper.
package mem_stage_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_D  = 3'b011;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;
    localparam logic [2:0] F3_WU = 3'b110;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_GNT,
        WAIT_RD
    } lsu_state_e;

    // log2 of the access size in bytes; the unused 3'b111 encoding counts as a byte
    function automatic logic [1:0] size_of_func3(input logic [2:0] f3);
        return (f3 == 3'b111) ? 2'd0 : f3[1:0];
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational store lane steering / byte-enable generation and load shift / extension.
module lsu_align
    import mem_stage_pkg::*;
#(
    parameter  int unsigned XLEN = 32,
    localparam int unsigned NB   = XLEN / 8,
    localparam int unsigned OB   = $clog2(NB)
) (
    input  logic [2:0]      i_st_func3,
    input  logic [OB-1:0]   i_st_off,
    input  logic [XLEN-1:0] i_st_data,
    output logic [NB-1:0]   o_web,
    output logic [XLEN-1:0] o_wdata,
    input  logic [2:0]      i_ld_func3,
    input  logic [OB-1:0]   i_ld_off,
    input  logic [XLEN-1:0] i_ld_data,
    output logic [XLEN-1:0] o_ld_data
);

    logic            w_st_ok;
    logic [NB-1:0]   w_lanes;
    logic [XLEN-1:0] w_sh;

    function automatic logic [XLEN-1:0] extend(input logic [XLEN-1:0] v,
                                               input int unsigned nbytes, input logic sgn);
        logic [XLEN-1:0] mask;
        mask = {XLEN{1'b1}} >> (XLEN - 8 * nbytes);
        if (sgn && |(v & (mask ^ (mask >> 1)))) return v | ~mask;
        return v & mask;
    endfunction

    always_comb begin
        w_st_ok = (i_st_func3 == F3_B) || (i_st_func3 == F3_H) || (i_st_func3 == F3_W) ||
                  ((XLEN == 64) && (i_st_func3 == F3_D));
        w_lanes = NB'((32'd1 << (32'd1 << size_of_func3(i_st_func3))) - 32'd1);
        o_web   = w_st_ok ? ~(w_lanes << i_st_off) : '1;
        o_wdata = i_st_data << {i_st_off, 3'b000};
    end

    always_comb begin
        w_sh      = i_ld_data >> {i_ld_off, 3'b000};
        o_ld_data = '0;
        case (i_ld_func3)
            F3_B:    o_ld_data = extend(w_sh, 1, 1'b1);
            F3_BU:   o_ld_data = extend(w_sh, 1, 1'b0);
            F3_H:    o_ld_data = extend(w_sh, 2, 1'b1);
            F3_HU:   o_ld_data = extend(w_sh, 2, 1'b0);
            F3_W:    o_ld_data = extend(w_sh, 4, 1'b1);
            F3_WU:   o_ld_data = (XLEN == 64) ? extend(w_sh, 4, 1'b0) : '0;
            F3_D:    o_ld_data = (XLEN == 64) ? w_sh : '0;
            default: o_ld_data = '0;
        endcase
    end

endmodule

// File: rtl/mem_stage_lsu.sv
// MEM stage LSU: req/gnt/rvalid data-memory handshake, pipeline stall and MEM/WB register.
// Define MISALIGN_TRAP_EN to flag misaligned accesses instead of aligning them down.
module mem_stage_lsu
    import mem_stage_pkg::*;
#(
    parameter  int unsigned XLEN   = 32,
    parameter  int unsigned ADDR_W = 32,
    parameter  int unsigned RD_W   = 5,
    localparam int unsigned NB     = XLEN / 8,
    localparam int unsigned OB     = $clog2(NB)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ex_valid,
    input  logic              ex_memread,
    input  logic              ex_memwrite,
    input  logic              ex_regwrite,
    input  logic [2:0]        ex_func3,
    input  logic [ADDR_W-1:0] ex_addr,
    input  logic [XLEN-1:0]   ex_wdata,
    input  logic [XLEN-1:0]   ex_rd_data,
    input  logic [RD_W-1:0]   ex_rd_addr,
    output logic              mem_stall,
    output logic              dm_req,
    output logic              dm_we,
    output logic [ADDR_W-1:0] dm_addr,
    output logic [NB-1:0]     dm_web,
    output logic [XLEN-1:0]   dm_wdata,
    input  logic              dm_gnt,
    input  logic              dm_rvalid,
    input  logic [XLEN-1:0]   dm_rdata,
    output logic              wb_valid,
    output logic              wb_regwrite,
    output logic [RD_W-1:0]   wb_rd_addr,
    output logic [XLEN-1:0]   wb_rd_data,
    output logic              mem_misalign
);

    lsu_state_e        r_state, w_state_nxt;
    logic [OB-1:0]     r_ld_off;
    logic              r_wb_valid, r_wb_regwrite, r_misalign;
    logic [RD_W-1:0]   r_wb_rd_addr;
    logic [XLEN-1:0]   r_wb_rd_data;

    logic              w_st_any, w_load, w_store, w_memop, w_mis;
    logic              w_req, w_done, w_stall;
    logic [OB-1:0]     w_off_raw, w_off, w_size_mask;
    logic [NB-1:0]     w_web;
    logic [XLEN-1:0]   w_wdata, w_ld_data;

    assign w_size_mask = OB'((32'd1 << size_of_func3(ex_func3)) - 32'd1);
    assign w_off_raw   = ex_addr[OB-1:0];
    assign w_off       = w_off_raw & ~w_size_mask;
    assign w_st_any    = ex_memwrite & ~ex_memread;

`ifdef MISALIGN_TRAP_EN
    assign w_mis = ex_valid & (ex_memread | ex_memwrite) & (|(w_off_raw & w_size_mask));
`else
    assign w_mis = 1'b0;
`endif

    assign w_load  = ex_valid & ex_memread & ~w_mis;
    assign w_store = ex_valid & w_st_any & ~w_mis;
    assign w_memop = w_load | w_store;

    always_comb begin
        w_state_nxt = r_state;
        w_req       = 1'b0;
        w_done      = 1'b0;
        unique case (r_state)
            IDLE, WAIT_GNT: begin
                w_req = w_memop;
                if (w_memop && dm_gnt) begin
                    w_state_nxt = w_load ? WAIT_RD : IDLE;
                    w_done      = w_store;
                end else begin
                    w_state_nxt = w_memop ? WAIT_GNT : IDLE;
                end
            end
            WAIT_RD: begin
                if (dm_rvalid) begin
                    w_state_nxt = IDLE;
                    w_done      = 1'b1;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    assign w_stall   = w_memop & ~w_done;
    assign mem_stall = w_stall;

    // Request and its qualifiers collapse to idle values as soon as reset asserts
    assign dm_req   = w_req & rst_n;
    assign dm_we    = dm_req & w_store;
    assign dm_addr  = dm_req ? {ex_addr[ADDR_W-1:OB], OB'(0)} : '0;
    assign dm_web   = dm_we ? w_web : '1;
    assign dm_wdata = dm_we ? w_wdata : '0;

    lsu_align #(
        .XLEN (XLEN)
    ) u_align (
        .i_st_func3 (ex_func3),
        .i_st_off   (w_off),
        .i_st_data  (ex_wdata),
        .o_web      (w_web),
        .o_wdata    (w_wdata),
        .i_ld_func3 (ex_func3),
        .i_ld_off   (r_ld_off),
        .i_ld_data  (dm_rdata),
        .o_ld_data  (w_ld_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= IDLE;
            r_ld_off      <= '0;
            r_wb_valid    <= 1'b0;
            r_wb_regwrite <= 1'b0;
            r_wb_rd_addr  <= '0;
            r_wb_rd_data  <= '0;
            r_misalign    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_req && dm_gnt) r_ld_off <= w_off;
            if (w_stall) begin
                r_wb_valid    <= 1'b0;
                r_wb_regwrite <= 1'b0;
                r_misalign    <= 1'b0;
            end else begin
                r_wb_valid    <= ex_valid;
                r_wb_regwrite <= ex_regwrite & ~w_st_any & ~w_mis;
                r_wb_rd_addr  <= ex_rd_addr;
                r_wb_rd_data  <= w_load ? w_ld_data : ex_rd_data;
                r_misalign    <= w_mis;
            end
        end
    end

    assign wb_valid     = r_wb_valid;
    assign wb_regwrite  = r_wb_regwrite;
    assign wb_rd_addr   = r_wb_rd_addr;
    assign wb_rd_data   = r_wb_rd_data;
    assign mem_misalign = r_misalign;

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Bench for mem_stage_lsu: XLEN=32 and XLEN=64 instances in lockstep against a byte-level model.
module tb_mem_stage_lsu;

`ifdef MISALIGN_TRAP_EN
    localparam bit TrapEn = 1'b1;
`else
    localparam bit TrapEn = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ex_valid, ex_memread, ex_memwrite, ex_regwrite;
    logic [2:0]  ex_func3;
    logic [31:0] ex_addr;
    logic [63:0] ex_wdata, ex_rd_data, dm_rdata;
    logic [4:0]  ex_rd_addr;
    logic        dm_gnt, dm_rvalid;

    logic        a_stall, a_req, a_we, a_wbv, a_wbrw, a_mis;
    logic [31:0] a_addr, a_wdata, a_wbd;
    logic [3:0]  a_web;
    logic [4:0]  a_wbrd;
    logic        b_stall, b_req, b_we, b_wbv, b_wbrw, b_mis;
    logic [31:0] b_addr;
    logic [63:0] b_wdata, b_wbd;
    logic [7:0]  b_web;
    logic [4:0]  b_wbrd;

    int n_vec = 0, n_err = 0;
    bit chk_en = 1'b0;
    bit e_req = 0, e_store = 0, e_stall = 0, e_wb_valid = 0, e_wb_rw = 0, e_mis = 0;
    logic [4:0]  e_wb_rd = '0;
    logic [63:0] e_wb_d32 = '0, e_wb_d64 = '0;
    int stall_cnt = 0, req_cnt = 0;
    logic [3:0]  cap_web = '0;
    logic [31:0] cap_wdata = '0, cap_addr = '0;

    always #5 clk = ~clk;

    mem_stage_lsu #(.XLEN(32), .ADDR_W(32), .RD_W(5)) u_dut32 (
        .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .ex_memread(ex_memread),
        .ex_memwrite(ex_memwrite), .ex_regwrite(ex_regwrite), .ex_func3(ex_func3),
        .ex_addr(ex_addr), .ex_wdata(ex_wdata[31:0]), .ex_rd_data(ex_rd_data[31:0]),
        .ex_rd_addr(ex_rd_addr), .mem_stall(a_stall), .dm_req(a_req), .dm_we(a_we),
        .dm_addr(a_addr), .dm_web(a_web), .dm_wdata(a_wdata), .dm_gnt(dm_gnt),
        .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata[31:0]), .wb_valid(a_wbv),
        .wb_regwrite(a_wbrw), .wb_rd_addr(a_wbrd), .wb_rd_data(a_wbd), .mem_misalign(a_mis)
    );

    mem_stage_lsu #(.XLEN(64), .ADDR_W(32), .RD_W(5)) u_dut64 (
        .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .ex_memread(ex_memread),
        .ex_memwrite(ex_memwrite), .ex_regwrite(ex_regwrite), .ex_func3(ex_func3),
        .ex_addr(ex_addr), .ex_wdata(ex_wdata), .ex_rd_data(ex_rd_data),
        .ex_rd_addr(ex_rd_addr), .mem_stall(b_stall), .dm_req(b_req), .dm_we(b_we),
        .dm_addr(b_addr), .dm_web(b_web), .dm_wdata(b_wdata), .dm_gnt(dm_gnt),
        .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata), .wb_valid(b_wbv),
        .wb_regwrite(b_wbrw), .wb_rd_addr(b_wbrd), .wb_rd_data(b_wbd), .mem_misalign(b_mis)
    );

    task automatic chk(input string nm, input int x, input logic [63:0] act, exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s (xlen %0d): got %h, want %h at %0t", nm, x, act, exp, $time);
        end
    endtask

    // Bytes moved by an access of this funct3, 0 when unsupported for this XLEN
    function automatic int acc_bytes(input logic [2:0] f3, input int x);
        case (f3)
            3'b000, 3'b100: return 1;
            3'b001, 3'b101: return 2;
            3'b010:         return 4;
            3'b110:         return (x == 64) ? 4 : 0;
            3'b011:         return (x == 64) ? 8 : 0;
            default:        return 0;
        endcase
    endfunction

    function automatic int nominal_size(input logic [2:0] f3);
        return (f3 == 3'b111) ? 1 : (1 << f3[1:0]);
    endfunction

    function automatic int eff_off(input logic [2:0] f3, input logic [31:0] a, input int x);
        int off = int'(a % (x / 8));
        return off - off % nominal_size(f3);
    endfunction

    function automatic bit misal(input logic [2:0] f3, input logic [31:0] a, input int x);
        return (a % (x / 8)) % nominal_size(f3) != 0;
    endfunction

    function automatic logic [63:0] ld_model(input logic [63:0] d, input logic [2:0] f3,
                                             input logic [31:0] a, input int x);
        int n = acc_bytes(f3, x);
        int off = eff_off(f3, a, x);
        logic [63:0] v = '0;
        if (n == 0) return '0;
        for (int i = 0; i < n; i++) v[8*i +: 8] = d[8*(off+i) +: 8];
        if (!f3[2] && v[8*n-1]) for (int i = 8 * n; i < 64; i++) v[i] = 1'b1;
        if (x == 32) v[63:32] = '0;
        return v;
    endfunction

    task automatic cmp_dut(input int x, input logic req, we, input logic [31:0] addr,
                           input logic [7:0] web, input logic [63:0] wdata,
                           input logic stall, wbv, wbrw, input logic [4:0] wbrd,
                           input logic [63:0] wbd, input logic mis);
        int nb = x / 8;
        int n, off;
        bit en;
        chk("dm_req", x, 64'(req), 64'(e_req));
        chk("mem_stall", x, 64'(stall), 64'(e_stall));
        chk("wb_valid", x, 64'(wbv), 64'(e_wb_valid));
        chk("mem_misalign", x, 64'(mis), 64'(e_mis));
        if (e_req) begin
            chk("dm_addr", x, 64'(addr), 64'(ex_addr - ex_addr % nb));
            chk("dm_we", x, 64'(we), 64'(e_store));
            if (e_store) begin
                n   = ex_func3[2] ? 0 : acc_bytes(ex_func3, x);
                off = eff_off(ex_func3, ex_addr, x);
                for (int i = 0; i < nb; i++) begin
                    en = (n > 0) && (i >= off) && (i < off + n);
                    chk("dm_web_lane", x, 64'(web[i]), 64'(!en));
                    if (en) chk("dm_wdata_lane", x, 64'(wdata[8*i +: 8]),
                                64'(ex_wdata[8*(i-off) +: 8]));
                end
            end
        end
        if (e_wb_valid) begin
            chk("wb_regwrite", x, 64'(wbrw), 64'(e_wb_rw));
            chk("wb_rd_addr", x, 64'(wbrd), 64'(e_wb_rd));
            chk("wb_rd_data", x, wbd, (x == 32) ? e_wb_d32 : e_wb_d64);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            cmp_dut(32, a_req, a_we, a_addr, {4'b0, a_web}, {32'b0, a_wdata}, a_stall, a_wbv,
                    a_wbrw, a_wbrd, {32'b0, a_wbd}, a_mis);
            cmp_dut(64, b_req, b_we, b_addr, b_web, b_wdata, b_stall, b_wbv, b_wbrw, b_wbrd,
                    b_wbd, b_mis);
            if (a_stall) stall_cnt++;
            if (a_req) begin
                req_cnt++;
                cap_web   = a_web;
                cap_wdata = a_wdata;
                cap_addr  = a_addr;
            end
        end
    end

    // One instruction: grant after g waiting cycles, read data r cycles after the grant
    task automatic run_op(input bit v, ld, st, rw, input logic [2:0] f3, input logic [31:0] a,
                          input logic [63:0] wd, rdv, rdat, input logic [4:0] rd,
                          input int g, r);
        bit load, store, mis;
        int total;
        load  = v && ld;
        store = v && st && !ld;
        mis   = TrapEn && (load || store) && misal(f3, a, 64);
        if (mis) begin
            load  = 1'b0;
            store = 1'b0;
        end
        total = !(load || store) ? 1 : (store ? g + 1 : g + r + 1);
        ex_valid = v; ex_memread = ld; ex_memwrite = st; ex_regwrite = rw; ex_func3 = f3;
        ex_addr = a; ex_wdata = wd; ex_rd_data = rdv; ex_rd_addr = rd;
        e_store = store;
        for (int c = 0; c < total; c++) begin
            e_req     = (load || store) && (c <= g);
            e_stall   = c < total - 1;
            dm_gnt    = e_req ? (c == g) : 1'($urandom);
            dm_rvalid = load && (c == g + r);
            dm_rdata  = dm_rvalid ? rdat : {$urandom, $urandom};
            @(posedge clk);
            #1;
            if (c == total - 1) begin
                e_wb_valid = v;
                e_wb_rw    = rw && !(st && !ld) && !mis;
                e_wb_rd    = rd;
                e_wb_d32   = load ? ld_model(rdat, f3, a, 32) : {32'b0, rdv[31:0]};
                e_wb_d64   = load ? ld_model(rdat, f3, a, 64) : rdv;
                e_mis      = mis;
            end else begin
                e_wb_valid = 1'b0;
                e_mis      = 1'b0;
            end
        end
        dm_gnt    = 1'b0;
        dm_rvalid = 1'b0;
    endtask

    task automatic reset_checks(input string tag);
        chk({tag, " dm_req"}, 32, 64'(a_req), 64'd0);
        chk({tag, " dm_req"}, 64, 64'(b_req), 64'd0);
        chk({tag, " dm_web"}, 32, 64'(a_web), 64'hF);
        chk({tag, " dm_web"}, 64, 64'(b_web), 64'hFF);
        chk({tag, " dm_addr"}, 64, 64'(b_addr), 64'd0);
        chk({tag, " dm_wdata"}, 64, b_wdata, 64'd0);
        chk({tag, " dm_we"}, 32, 64'(a_we), 64'd0);
        chk({tag, " wb_valid"}, 32, 64'(a_wbv), 64'd0);
        chk({tag, " wb_valid"}, 64, 64'(b_wbv), 64'd0);
        chk({tag, " wb_regwrite"}, 64, 64'(b_wbrw), 64'd0);
        chk({tag, " wb_rd_addr"}, 32, 64'(a_wbrd), 64'd0);
        chk({tag, " wb_rd_data"}, 64, b_wbd, 64'd0);
        chk({tag, " mem_misalign"}, 32, 64'(a_mis), 64'd0);
    endtask

    initial begin
        int kind;
        bit v, ld, st;
        logic [2:0] f3;
        logic [31:0] a;
        rst_n = 1'b0;
        ex_valid = 0; ex_memread = 0; ex_memwrite = 0; ex_regwrite = 0; ex_func3 = '0;
        ex_addr = '0; ex_wdata = '0; ex_rd_data = '0; ex_rd_addr = '0;
        dm_gnt = 0; dm_rvalid = 0; dm_rdata = '0;
        #3;
        reset_checks("reset");
        @(posedge clk);
        #1;
        rst_n  = 1'b1;
        chk_en = 1'b1;

        // SB at 0x103, zero-wait grant
        stall_cnt = 0;
        run_op(1, 0, 1, 1, 3'b000, 32'h103, 64'hAABBCCDD, 64'h5, 64'h0, 5'd3, 0, 1);
        chk("sb web literal", 32, 64'(cap_web), 64'h7);
        chk("sb wdata literal", 32, 64'(cap_wdata), 64'hDD000000);
        chk("sb stall cycles", 32, 64'(stall_cnt), 64'd0);

        // LH at 0x102, two grant wait states, rvalid three cycles after grant
        stall_cnt = 0;
        run_op(1, 1, 0, 1, 3'b001, 32'h102, 64'h0, 64'h0, 64'h80011234, 5'd7, 2, 3);
        chk("lh stall cycles", 32, 64'(stall_cnt), 64'd5);
        chk("lh data literal", 32, 64'(a_wbd), 64'hFFFF8001);
        chk("lh regwrite literal", 32, 64'(a_wbrw), 64'd1);

        run_op(1, 1, 0, 1, 3'b100, 32'h101, 64'h0, 64'h0, 64'h0000F000, 5'd8, 1, 1);
        chk("lbu data literal", 32, 64'(a_wbd), 64'hF0);

        run_op(1, 1, 0, 1, 3'b010, 32'h4, 64'h0, 64'h0, 64'h8000_0000_0000_0000, 5'd9, 0, 2);
        chk("lw64 data literal", 64, b_wbd, 64'hFFFF_FFFF_8000_0000);
        run_op(1, 1, 0, 1, 3'b110, 32'h4, 64'h0, 64'h0, 64'h8000_0000_0000_0000, 5'd9, 1, 1);
        chk("lwu64 data literal", 64, b_wbd, 64'h0000_0000_8000_0000);

        // SW at 0x102: trapped or aligned down depending on build
        req_cnt = 0;
        run_op(1, 0, 1, 1, 3'b010, 32'h102, 64'h11223344, 64'h0, 64'h0, 5'd4, 0, 1);
`ifdef MISALIGN_TRAP_EN
        chk("sw misalign req cycles", 32, 64'(req_cnt), 64'd0);
        chk("sw misalign flag", 32, 64'(a_mis), 64'd1);
        chk("sw misalign regwrite", 32, 64'(a_wbrw), 64'd0);
`else
        chk("sw aligned addr", 32, 64'(cap_addr), 64'h100);
        chk("sw aligned web", 32, 64'(cap_web), 64'h0);
`endif

        // Reset while a load waits for read data, then the same load runs cleanly
        chk_en = 1'b0;
        ex_valid = 1; ex_memread = 1; ex_memwrite = 0; ex_regwrite = 1; ex_func3 = 3'b010;
        ex_addr = 32'h200; ex_rd_addr = 5'd12;
        dm_gnt = 1'b1;
        @(posedge clk);
        #1;
        dm_gnt = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        reset_checks("midreset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        e_wb_valid = 0; e_mis = 0;
        chk_en = 1'b1;
        run_op(1, 1, 0, 1, 3'b010, 32'h200, 64'h0, 64'h0, 64'hCAFE_F00D_8765_4321, 5'd12, 1, 2);
        chk("post-reset load literal", 32, 64'(a_wbd), 64'h87654321);

        for (int k = 0; k < 300; k++) begin
            kind = $urandom_range(0, 9);
            v  = kind != 0;
            ld = (kind >= 1 && kind <= 4);
            st = (kind >= 5 && kind <= 7);
            if (kind == 0) begin
                ld = 1'($urandom);
                st = !ld;
            end
            f3 = 3'($urandom);
            a  = $urandom;
            // keep doubleword misalignment identical for both widths
            if (f3[1:0] == 2'b11 && a[2:0] == 3'b100) a[2] = 1'b0;
            run_op(v, ld, st, 1'($urandom), f3, a, {$urandom, $urandom}, {$urandom, $urandom},
                   {$urandom, $urandom}, 5'($urandom), $urandom_range(0, 3),
                   $urandom_range(1, 3));
        end

        @(posedge clk);
        #1;
        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
